// File: rtl/serial_adder_if.sv
`default_nettype none
// ==========================================================================
// serial_adder_if : operand/result valid-ready bundle for serial_adder. Rev 1.0
// ==========================================================================
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ==========================================================================
// serial_adder : bit-serial LSB-first adder, parallel in/out, valid/ready. Rev 1.0
// ==========================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  serial_adder_if.slave    bus
);
  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  // Two cascaded half-adder cells form the full-adder bit slice.
  logic ha0_s, ha0_c, ha1_s, ha1_c, carry_nxt;
  assign ha0_s     = a_sh_q[0] ^ b_sh_q[0];
  assign ha0_c     = a_sh_q[0] & b_sh_q[0];
  assign ha1_s     = ha0_s ^ carry_q;
  assign ha1_c     = ha0_s & carry_q;
  assign carry_nxt = ha0_c | ha1_c;

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d     = bus.a;
          b_sh_d     = bus.b;
          carry_d    = bus.cin;
          sum_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_d   = (sum_q >> 1) | (WIDTH'(ha1_s) << (WIDTH - 1));
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cout_d      = carry_nxt;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        // No accept on the DONE->IDLE edge: in_ready only rises afterwards.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ==========================================================================
// tb_serial_adder : self-checking bench, WIDTH 8/4/1 against a+b+cin. Rev 1.0
// ==========================================================================
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      8:       return if8.out_valid;
      4:       return if4.out_valid;
      default: return if1.out_valid;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      8:       return if8.in_ready;
      4:       return if4.in_ready;
      default: return if1.in_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      8:       return if8.busy;
      4:       return if4.busy;
      default: return if1.busy;
    endcase
  endfunction

  function automatic logic [31:0] get_result(input int w);
    case (w)
      8:       return 32'({if8.cout, if8.sum});
      4:       return 32'({if4.cout, if4.sum});
      default: return 32'({if1.cout, if1.sum});
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic ci);
    case (w)
      8: begin if8.in_valid = v; if8.a = a;      if8.b = b;      if8.cin = ci; end
      4: begin if4.in_valid = v; if4.a = a[3:0]; if4.b = b[3:0]; if4.cin = ci; end
      default: begin if1.in_valid = v; if1.a = a[0]; if1.b = b[0]; if1.cin = ci; end
    endcase
  endtask

  task automatic set_or(input int w, input logic r);
    case (w)
      8:       if8.out_ready = r;
      4:       if4.out_ready = r;
      default: if1.out_ready = r;
    endcase
  endtask

  // Reference: {cout,sum} of a w-bit adder is simply the integer a+b+cin.
  function automatic logic [31:0] ref_sum(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic ci);
    int mask;
    mask = (1 << w) - 1;
    return 32'((int'(a) & mask) + (int'(b) & mask) + int'(ci));
  endfunction

  task automatic start_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci);
    int k;
    k = 0;
    while (!get_ir(w) && k < 100) begin
      @(negedge clk);
      k++;
    end
    drive(w, 1'b1, a, b, ci);
    @(negedge clk);
    drive(w, 1'b0, a, b, ci);
  endtask

  task automatic wait_done(input int w, output int lat);
    lat = 0;
    while (!get_ov(w) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op(input int w);
    set_or(w, 1'b1);
    @(negedge clk);
    set_or(w, 1'b0);
  endtask

  task automatic full_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input string tag);
    int lat;
    start_op(w, a, b, ci);
    wait_done(w, lat);
    check({tag, "_lat"}, 32'(lat), 32'(w));
    check({tag, "_res"}, get_result(w), ref_sum(w, a, b, ci));
    release_op(w);
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic rc;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0); set_or(8, 1'b0);
    drive(4, 1'b0, 8'd0, 8'd0, 1'b0); set_or(4, 1'b0);
    drive(1, 1'b0, 8'd0, 8'd0, 1'b0); set_or(1, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_in_ready", 32'(if8.in_ready), 32'd1);
    check("rst_out_valid", 32'(if8.out_valid), 32'd0);
    check("rst_busy", 32'(if8.busy), 32'd0);
    check("rst_sum", 32'(if8.sum), 32'd0);
    check("rst_cout", 32'(if8.cout), 32'd0);

    // Directed arithmetic cases, including both carry-out boundaries.
    full_op(8, 8'd3, 8'd5, 1'b0, "3p5");
    full_op(8, 8'd255, 8'd1, 1'b0, "255p1");
    full_op(8, 8'd255, 8'd255, 1'b1, "255p255c");

    // Hold in DONE with out_ready low while in_valid pulses with junk operands.
    start_op(8, 8'd100, 8'd200, 1'b1);
    check("hold_busy", 32'(if8.busy), 32'd1);
    wait_done(8, lat);
    check("hold_lat", 32'(lat), 32'd8);
    for (int i = 0; i < 5; i++) begin
      drive(8, 1'(i % 2), 8'($urandom), 8'($urandom), 1'b0);
      @(negedge clk);
      check("hold_ov", 32'(if8.out_valid), 32'd1);
      check("hold_ir", 32'(if8.in_ready), 32'd0);
      check("hold_res", get_result(8), 32'd301);
    end
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    release_op(8);
    check("rel_ir", 32'(if8.in_ready), 32'd1);
    check("rel_ov", 32'(if8.out_valid), 32'd0);
    check("rel_busy", 32'(if8.busy), 32'd0);

    // in_valid held high across a whole operation with changing operands.
    drive(8, 1'b1, 8'd10, 8'd20, 1'b0);
    @(negedge clk);
    check("hv_busy", 32'(if8.busy), 32'd1);
    drive(8, 1'b1, 8'd100, 8'd50, 1'b0);
    wait_done(8, lat);
    check("hv_lat1", 32'(lat), 32'd8);
    check("hv_res1", get_result(8), ref_sum(8, 8'd10, 8'd20, 1'b0));
    release_op(8);
    check("hv_idle_gap", 32'(if8.in_ready), 32'd1);
    @(negedge clk);
    check("hv_accept2", 32'(if8.busy), 32'd1);
    drive(8, 1'b0, 8'd0, 8'd0, 1'b0);
    wait_done(8, lat);
    check("hv_lat2", 32'(lat), 32'd8);
    check("hv_res2", get_result(8), ref_sum(8, 8'd100, 8'd50, 1'b0));
    release_op(8);

    // Asynchronous reset three cycles into SHIFT.
    start_op(8, 8'd255, 8'd255, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_in_ready", 32'(if8.in_ready), 32'd1);
    check("ar_out_valid", 32'(if8.out_valid), 32'd0);
    check("ar_busy", 32'(if8.busy), 32'd0);
    check("ar_sum", 32'(if8.sum), 32'd0);
    check("ar_cout", 32'(if8.cout), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_op(8, 8'd10, 8'd20, 1'b0, "post_rst");

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      full_op(8, ra, rb, rc, "rand8");
    end

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          full_op(4, 8'(a), 8'(b), 1'(c), "exh4");

    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          full_op(1, 8'(a), 8'(b), 1'(c), "exh1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
